// File: rtl/silbusb_bus_bridge_if.sv
// Pin-side and bus-side signals of the SiLibUSB bridge, bundled for the bridge (slave) and its environment (master).
// Strobes RD_B/WR_B are level, active low; BUS_RD/BUS_WR/FIFO_READ are single-cycle pulses sampled at the next clock edge, no back-pressure.
interface silbusb_bus_bridge_if;
  logic [15:0] USB_ADD;
  logic        USB_RD_B;
  logic        USB_WR_B;
  logic        USB_FREAD;
  logic        USB_FSTROBE;
  logic        USB_FMODE;
  logic [7:0]  USB_FD;
  logic [15:0] BUS_ADD;
  logic        BUS_RD;
  logic        BUS_WR;
  logic [7:0]  FIFO_DATA;
  logic        FIFO_EMPTY;
  logic        FIFO_READ;
  logic [7:0]  UNDERFLOW_CNT;
  // Tristate enables of USB_DATA and BUS_DATA, exposed for observation.
  logic        usb_data_oe;
  logic        bus_data_oe;

  modport slave (
    input  USB_ADD, USB_RD_B, USB_WR_B, USB_FREAD, USB_FSTROBE, USB_FMODE,
    input  FIFO_DATA, FIFO_EMPTY,
    output USB_FD, BUS_ADD, BUS_RD, BUS_WR, FIFO_READ, UNDERFLOW_CNT,
    output usb_data_oe, bus_data_oe
  );

  modport master (
    output USB_ADD, USB_RD_B, USB_WR_B, USB_FREAD, USB_FSTROBE, USB_FMODE,
    output FIFO_DATA, FIFO_EMPTY,
    input  USB_FD, BUS_ADD, BUS_RD, BUS_WR, FIFO_READ, UNDERFLOW_CNT,
    input  usb_data_oe, bus_data_oe
  );
endinterface

// File: rtl/silbusb_bus_bridge.sv
// SiLibUSB to basil bus bridge: strobe edges become one-cycle BUS_RD/BUS_WR pulses,
// and the fast-read port is served from an FWFT FIFO through a one-word prefetch register.
module silbusb_bus_bridge #(
  parameter logic [15:0] BASEADDR = 16'h4000
) (
  input  logic                       BUS_CLK,
  input  logic                       BUS_RST,
  silbusb_bus_bridge_if.slave        bus,
  inout  wire  [7:0]                 USB_DATA,
  inout  wire  [7:0]                 BUS_DATA
);

  logic       rd_b_q, rd_b_d;
  logic       wr_b_q, wr_b_d;
  logic       rd_act_q, rd_act_d;
  logic       rd_first_q, rd_first_d;
  logic [7:0] rd_hold_q, rd_hold_d;
  logic       fd_v_q, fd_v_d;
  logic [7:0] fd_q, fd_d;
  logic [7:0] cnt_q, cnt_d;

  logic       in_win;
  logic       bus_rd;
  logic       bus_wr;
  logic       take;
  logic       fifo_read;
  logic       usb_oe;
  logic [7:0] usb_out;

  always_comb begin
    in_win    = (bus.USB_ADD >= BASEADDR);
    // Write wins a simultaneous fall; the read edge is then consumed without a pulse.
    bus_wr    = ~BUS_RST & in_win & ~bus.USB_WR_B & wr_b_q;
    bus_rd    = ~BUS_RST & in_win & ~bus.USB_RD_B & rd_b_q & ~bus_wr;
    take      = bus.USB_FREAD & bus.USB_FSTROBE & ~bus.USB_FMODE;
    fifo_read = ~BUS_RST & ~bus.FIFO_EMPTY & (~fd_v_q | take);
    usb_oe    = ~BUS_RST & rd_act_q & ~bus.USB_RD_B;
    // First data cycle forwards the peripheral directly; later cycles replay the held byte.
    usb_out   = rd_first_q ? BUS_DATA : rd_hold_q;

    rd_b_d     = bus.USB_RD_B;
    wr_b_d     = bus.USB_WR_B;
    rd_first_d = bus_rd;
    rd_act_d   = bus.USB_RD_B ? 1'b0 : (bus_rd | rd_act_q);
    rd_hold_d  = rd_first_q ? BUS_DATA : rd_hold_q;

    fd_d   = fd_q;
    fd_v_d = fd_v_q;
    if (fifo_read) begin
      fd_d   = bus.FIFO_DATA;
      fd_v_d = 1'b1;
    end else if (take) begin
      fd_v_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (take && !fd_v_q && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      rd_b_q     <= 1'b0;
      wr_b_q     <= 1'b0;
      rd_act_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rd_hold_q  <= 8'h00;
      fd_v_q     <= 1'b0;
      fd_q       <= 8'h00;
      cnt_q      <= 8'h00;
    end else begin
      rd_b_q     <= rd_b_d;
      wr_b_q     <= wr_b_d;
      rd_act_q   <= rd_act_d;
      rd_first_q <= rd_first_d;
      rd_hold_q  <= rd_hold_d;
      fd_v_q     <= fd_v_d;
      fd_q       <= fd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.BUS_ADD       = bus.USB_ADD - BASEADDR;
  assign bus.BUS_RD        = bus_rd;
  assign bus.BUS_WR        = bus_wr;
  assign bus.FIFO_READ     = fifo_read;
  assign bus.USB_FD        = fd_v_q ? fd_q : 8'h00;
  assign bus.UNDERFLOW_CNT = cnt_q;
  assign bus.usb_data_oe   = usb_oe;
  assign bus.bus_data_oe   = bus_wr;

  assign USB_DATA = usb_oe ? usb_out : 8'bz;
  assign BUS_DATA = bus_wr ? USB_DATA : 8'bz;

endmodule

// File: tb/tb_silbusb_bus_bridge.sv
// Directed bench for silbusb_bus_bridge: host strobes, peripheral read return, FWFT FIFO fast reads and reset.
module tb_silbusb_bus_bridge;
  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] usb_data;
  wire  [7:0] bus_data;
  logic       host_en;
  logic [7:0] host_val;
  logic       periph_en = 1'b0;
  logic [7:0] periph_val;
  logic [7:0] fifo_mem [8];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  int         checks = 0;
  int         errors = 0;

  silbusb_bus_bridge_if bus_if ();

  silbusb_bus_bridge #(.BASEADDR(16'h4000)) dut (
    .BUS_CLK  (clk),
    .BUS_RST  (rst),
    .bus      (bus_if),
    .USB_DATA (usb_data),
    .BUS_DATA (bus_data)
  );

  always #5 clk = ~clk;

  assign usb_data          = host_en ? host_val : 8'bz;
  assign bus_data          = periph_en ? periph_val : 8'bz;
  assign bus_if.FIFO_EMPTY = (rd_ptr == wr_ptr);
  assign bus_if.FIFO_DATA  = fifo_mem[rd_ptr[2:0]];

  // Peripheral answers the cycle after BUS_RD; FIFO pops on FIFO_READ.
  always @(posedge clk) begin
    periph_en <= bus_if.BUS_RD;
    if (bus_if.FIFO_READ) rd_ptr <= rd_ptr + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic push_fifo(input logic [7:0] v);
    fifo_mem[wr_ptr % 8] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.USB_ADD = 16'h4000;
    bus_if.USB_RD_B = 1'b0;
    bus_if.USB_WR_B = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus_if.BUS_RD !== 1'b0 || bus_if.BUS_WR !== 1'b0) begin errors++; $display("FAIL rst_pulses rd=%0b wr=%0b exp 0 0", bus_if.BUS_RD, bus_if.BUS_WR); end
    checks++; if (bus_if.FIFO_READ !== 1'b0 || bus_if.USB_FD !== 8'h00 || bus_if.UNDERFLOW_CNT !== 8'h00) begin errors++; $display("FAIL rst_fast fr=%0b fd=%h cnt=%h exp 0 00 00", bus_if.FIFO_READ, bus_if.USB_FD, bus_if.UNDERFLOW_CNT); end
    checks++; if (bus_if.usb_data_oe !== 1'b0 || bus_if.bus_data_oe !== 1'b0) begin errors++; $display("FAIL rst_oe usb=%0b bus=%0b exp 0 0", bus_if.usb_data_oe, bus_if.bus_data_oe); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (bus_if.BUS_RD !== 1'b0 || bus_if.BUS_WR !== 1'b0) begin errors++; $display("FAIL held_strobe rd=%0b wr=%0b exp 0 0", bus_if.BUS_RD, bus_if.BUS_WR); end
    @(negedge clk);
    bus_if.USB_RD_B = 1'b1;
    bus_if.USB_WR_B = 1'b1;
    bus_if.USB_ADD = 16'h0000;
    @(negedge clk);
  endtask

  task automatic test_write();
    bus_if.USB_ADD = 16'h4012; host_val = 8'hA5; host_en = 1'b1; bus_if.USB_WR_B = 1'b0;
    #1;
    checks++; if (bus_if.BUS_WR !== 1'b1 || bus_if.BUS_RD !== 1'b0) begin errors++; $display("FAIL wr_pulse wr=%0b rd=%0b exp 1 0", bus_if.BUS_WR, bus_if.BUS_RD); end
    checks++; if (bus_if.BUS_ADD !== 16'h0012) begin errors++; $display("FAIL wr_addr got %h exp 0012", bus_if.BUS_ADD); end
    checks++; if (bus_if.bus_data_oe !== 1'b1 || bus_data !== 8'hA5) begin errors++; $display("FAIL wr_data oe=%0b got %h exp 1 a5", bus_if.bus_data_oe, bus_data); end
    @(negedge clk); #1;
    checks++; if (bus_if.BUS_WR !== 1'b0 || bus_if.bus_data_oe !== 1'b0) begin errors++; $display("FAIL wr_once wr=%0b oe=%0b exp 0 0", bus_if.BUS_WR, bus_if.bus_data_oe); end
    @(negedge clk);
    bus_if.USB_WR_B = 1'b1; host_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    bus_if.USB_ADD = 16'h4034; periph_val = 8'h5C; bus_if.USB_RD_B = 1'b0;
    #1;
    checks++; if (bus_if.BUS_RD !== 1'b1 || bus_if.BUS_ADD !== 16'h0034) begin errors++; $display("FAIL rd_pulse rd=%0b add=%h exp 1 0034", bus_if.BUS_RD, bus_if.BUS_ADD); end
    checks++; if (bus_if.usb_data_oe !== 1'b0) begin errors++; $display("FAIL rd_c0_oe got %0b exp 0", bus_if.usb_data_oe); end
    @(negedge clk); #1;
    checks++; if (bus_if.BUS_RD !== 1'b0) begin errors++; $display("FAIL rd_once got %0b exp 0", bus_if.BUS_RD); end
    checks++; if (bus_if.usb_data_oe !== 1'b1 || usb_data !== 8'h5C) begin errors++; $display("FAIL rd_c1_data oe=%0b got %h exp 1 5c", bus_if.usb_data_oe, usb_data); end
    @(negedge clk); #1;
    checks++; if (bus_if.usb_data_oe !== 1'b1 || usb_data !== 8'h5C) begin errors++; $display("FAIL rd_hold oe=%0b got %h exp 1 5c", bus_if.usb_data_oe, usb_data); end
    bus_if.USB_RD_B = 1'b1; #1;
    checks++; if (bus_if.usb_data_oe !== 1'b0) begin errors++; $display("FAIL rd_release oe=%0b exp 0", bus_if.usb_data_oe); end
    @(negedge clk);
  endtask

  task automatic test_out_of_window();
    bus_if.USB_ADD = 16'h3FFF; bus_if.USB_RD_B = 1'b0;
    #1;
    checks++; if (bus_if.BUS_RD !== 1'b0) begin errors++; $display("FAIL oow_rd got %0b exp 0", bus_if.BUS_RD); end
    @(negedge clk); #1;
    checks++; if (bus_if.usb_data_oe !== 1'b0) begin errors++; $display("FAIL oow_oe got %0b exp 0", bus_if.usb_data_oe); end
    bus_if.USB_RD_B = 1'b1;
    @(negedge clk);
    host_val = 8'h11; host_en = 1'b1; bus_if.USB_WR_B = 1'b0; #1;
    checks++; if (bus_if.BUS_WR !== 1'b0 || bus_if.bus_data_oe !== 1'b0) begin errors++; $display("FAIL oow_wr wr=%0b oe=%0b exp 0 0", bus_if.BUS_WR, bus_if.bus_data_oe); end
    @(negedge clk);
    bus_if.USB_WR_B = 1'b1; host_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    bus_if.USB_ADD = 16'h4010; host_val = 8'h3A; host_en = 1'b1;
    bus_if.USB_RD_B = 1'b0; bus_if.USB_WR_B = 1'b0; #1;
    checks++; if (bus_if.BUS_WR !== 1'b1 || bus_if.BUS_RD !== 1'b0) begin errors++; $display("FAIL sim_edge wr=%0b rd=%0b exp 1 0", bus_if.BUS_WR, bus_if.BUS_RD); end
    @(negedge clk); #1;
    checks++; if (bus_if.BUS_RD !== 1'b0 || bus_if.usb_data_oe !== 1'b0) begin errors++; $display("FAIL sim_suppress rd=%0b oe=%0b exp 0 0", bus_if.BUS_RD, bus_if.usb_data_oe); end
    bus_if.USB_RD_B = 1'b1; bus_if.USB_WR_B = 1'b1; host_en = 1'b0;
    @(negedge clk);
    periph_val = 8'h99; bus_if.USB_RD_B = 1'b0; #1;
    checks++; if (bus_if.BUS_RD !== 1'b1 || bus_if.BUS_ADD !== 16'h0010) begin errors++; $display("FAIL sim_rearm rd=%0b add=%h exp 1 0010", bus_if.BUS_RD, bus_if.BUS_ADD); end
    @(negedge clk);
    bus_if.USB_RD_B = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fifo();
    logic [7:0] exp_fd [4];
    logic       exp_fr [4];
    exp_fd = '{8'h01, 8'h02, 8'h03, 8'h00};
    exp_fr = '{1'b1, 1'b1, 1'b0, 1'b0};
    push_fifo(8'h01); push_fifo(8'h02); push_fifo(8'h03);
    #1;
    checks++; if (bus_if.FIFO_READ !== 1'b1 || bus_if.USB_FD !== 8'h00) begin errors++; $display("FAIL prefetch fr=%0b fd=%h exp 1 00", bus_if.FIFO_READ, bus_if.USB_FD); end
    @(negedge clk);
    bus_if.USB_FREAD = 1'b1; bus_if.USB_FSTROBE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus_if.USB_FD !== exp_fd[i] || bus_if.FIFO_READ !== exp_fr[i]) begin errors++; $display("FAIL take_%0d fd=%h fr=%0b exp %h %0b", i, bus_if.USB_FD, bus_if.FIFO_READ, exp_fd[i], exp_fr[i]); end
      @(negedge clk);
    end
    bus_if.USB_FREAD = 1'b0; bus_if.USB_FSTROBE = 1'b0; #1;
    checks++; if (bus_if.UNDERFLOW_CNT !== 8'h01) begin errors++; $display("FAIL underflow_1 got %h exp 01", bus_if.UNDERFLOW_CNT); end
    @(negedge clk);
  endtask

  task automatic test_fmode();
    push_fifo(8'h77);
    @(negedge clk);
    push_fifo(8'h88); #1;
    checks++; if (bus_if.USB_FD !== 8'h77 || bus_if.FIFO_READ !== 1'b0) begin errors++; $display("FAIL fm_pre fd=%h fr=%0b exp 77 0", bus_if.USB_FD, bus_if.FIFO_READ); end
    bus_if.USB_FMODE = 1'b1; bus_if.USB_FREAD = 1'b1; bus_if.USB_FSTROBE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus_if.FIFO_READ !== 1'b0 || bus_if.USB_FD !== 8'h77) begin errors++; $display("FAIL fm_ignore_%0d fr=%0b fd=%h exp 0 77", i, bus_if.FIFO_READ, bus_if.USB_FD); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus_if.UNDERFLOW_CNT !== 8'h01 || rd_ptr != 4) begin errors++; $display("FAIL fm_state cnt=%h pops=%0d exp 01 4", bus_if.UNDERFLOW_CNT, rd_ptr); end
    bus_if.USB_FMODE = 1'b0; #1;
    checks++; if (bus_if.USB_FD !== 8'h77 || bus_if.FIFO_READ !== 1'b1) begin errors++; $display("FAIL fm_take fd=%h fr=%0b exp 77 1", bus_if.USB_FD, bus_if.FIFO_READ); end
    @(negedge clk); #1;
    checks++; if (bus_if.USB_FD !== 8'h88 || bus_if.FIFO_READ !== 1'b0) begin errors++; $display("FAIL fm_next fd=%h fr=%0b exp 88 0", bus_if.USB_FD, bus_if.FIFO_READ); end
    @(negedge clk); #1;
    checks++; if (bus_if.USB_FD !== 8'h00 || bus_if.UNDERFLOW_CNT !== 8'h01) begin errors++; $display("FAIL fm_drain fd=%h cnt=%h exp 00 01", bus_if.USB_FD, bus_if.UNDERFLOW_CNT); end
    @(negedge clk); #1;
    checks++; if (bus_if.UNDERFLOW_CNT !== 8'h02) begin errors++; $display("FAIL underflow_2 got %h exp 02", bus_if.UNDERFLOW_CNT); end
  endtask

  task automatic test_saturate();
    // Take is still asserted from the previous scenario; counter starts at 2.
    repeat (252) @(negedge clk);
    #1;
    checks++; if (bus_if.UNDERFLOW_CNT !== 8'hFE) begin errors++; $display("FAIL sat_fe got %h exp fe", bus_if.UNDERFLOW_CNT); end
    repeat (8) @(negedge clk);
    bus_if.USB_FREAD = 1'b0; bus_if.USB_FSTROBE = 1'b0; #1;
    checks++; if (bus_if.UNDERFLOW_CNT !== 8'hFF || bus_if.USB_FD !== 8'h00) begin errors++; $display("FAIL sat_ff cnt=%h fd=%h exp ff 00", bus_if.UNDERFLOW_CNT, bus_if.USB_FD); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    bus_if.USB_ADD = 16'h4034; periph_val = 8'hC3; bus_if.USB_RD_B = 1'b0; #1;
    checks++; if (bus_if.BUS_RD !== 1'b1) begin errors++; $display("FAIL mr_start got %0b exp 1", bus_if.BUS_RD); end
    @(negedge clk); #1;
    checks++; if (bus_if.usb_data_oe !== 1'b1 || usb_data !== 8'hC3) begin errors++; $display("FAIL mr_data oe=%0b got %h exp 1 c3", bus_if.usb_data_oe, usb_data); end
    rst = 1'b1; #1;
    checks++; if (bus_if.usb_data_oe !== 1'b0 || bus_if.BUS_RD !== 1'b0) begin errors++; $display("FAIL mr_in_rst oe=%0b rd=%0b exp 0 0", bus_if.usb_data_oe, bus_if.BUS_RD); end
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (bus_if.usb_data_oe !== 1'b0 || bus_if.BUS_RD !== 1'b0 || bus_if.UNDERFLOW_CNT !== 8'h00) begin errors++; $display("FAIL mr_after oe=%0b rd=%0b cnt=%h exp 0 0 00", bus_if.usb_data_oe, bus_if.BUS_RD, bus_if.UNDERFLOW_CNT); end
    @(negedge clk); #1;
    checks++; if (bus_if.usb_data_oe !== 1'b0 || bus_if.BUS_RD !== 1'b0) begin errors++; $display("FAIL mr_hold oe=%0b rd=%0b exp 0 0", bus_if.usb_data_oe, bus_if.BUS_RD); end
    bus_if.USB_RD_B = 1'b1;
    @(negedge clk);
    periph_val = 8'h3C; bus_if.USB_RD_B = 1'b0; #1;
    checks++; if (bus_if.BUS_RD !== 1'b1) begin errors++; $display("FAIL mr_fresh got %0b exp 1", bus_if.BUS_RD); end
    @(negedge clk); #1;
    checks++; if (bus_if.usb_data_oe !== 1'b1 || usb_data !== 8'h3C) begin errors++; $display("FAIL mr_fresh_data oe=%0b got %h exp 1 3c", bus_if.usb_data_oe, usb_data); end
    bus_if.USB_RD_B = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    host_en = 1'b0; host_val = 8'h00; periph_val = 8'h00;
    bus_if.USB_ADD = 16'h0000;
    bus_if.USB_RD_B = 1'b1; bus_if.USB_WR_B = 1'b1;
    bus_if.USB_FREAD = 1'b0; bus_if.USB_FSTROBE = 1'b0; bus_if.USB_FMODE = 1'b0;
    for (int i = 0; i < 8; i++) fifo_mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_out_of_window();
    test_simultaneous();
    test_fifo();
    test_fmode();
    test_saturate();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
